exec_pip0: RTL and testbench

Execution/writeback unit on the consumer side of the pipe-0 reservation station. Each cycle it inspects the station's two ready candidates and drives the one-hot select that pops one of them. It takes the selected operands in the same cycle and executes ALU ops in one cycle or MUL in an iterative 4-cycle unit. It then broadcasts the result (register address + data) on the update bus that feeds the station's operand wakeup.

---
 rtl/exec_pip0.sv | 166 ++++++++++++++++
 tb/tb_exec_pip0.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_pip0.sv
// Pipe-0 execution/writeback unit: picks one of two reservation-station candidates,
// executes ALU ops in one cycle or MUL over four, and broadcasts the result.
module exec_pip0 #(
    parameter int W_PA_REG  = 5,
    parameter int W_PD_UOPS = 6,
    parameter int W_PD_DATA = 32,
    parameter int W_PC_SEL  = 2,
    parameter int MUL_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 CFI_PC_clear,
    input  logic                 CFI_PC_ena,
    input  logic                 CFI_PC_stall,
    input  logic [W_PD_UOPS-1:0] CDI_PD_uops0,
    input  logic [W_PD_UOPS-1:0] CDI_PD_uops1,
    input  logic                 CDI_PC_odr,
    input  logic [W_PA_REG-1:0]  CDI_PA_r1,
    input  logic [W_PA_REG-1:0]  CDI_PA_r2,
    input  logic [W_PD_UOPS-1:0] DFI_PD_uops,
    input  logic [W_PD_DATA-1:0] DFI_PD_rs,
    input  logic [W_PD_DATA-1:0] DFI_PD_rt,
    input  logic [W_PD_DATA-1:0] DFI_PD_imm,
    input  logic [31:0]          DFI_AA_pc,
    output logic [W_PC_SEL-1:0]  CDO_PC_s1,
    output logic                 CDO_PV_upt1,
    output logic [W_PA_REG-1:0]  CDO_PA_upt1,
    output logic [W_PD_DATA-1:0] CDO_PD_upt1,
    output logic                 CFO_PC_mbusy
);

    localparam logic [W_PD_UOPS-1:0] UNUSED_OP = '1;
    localparam logic [2:0] CLS_ALU_RR = 3'b000;
    localparam logic [2:0] CLS_ALU_RI = 3'b001;
    localparam logic [2:0] CLS_MUL    = 3'b010;
    localparam int W_SLICE = W_PD_DATA / MUL_LAT;
    localparam int W_MCNT  = $clog2(MUL_LAT);
    localparam logic [W_MCNT-1:0] MCNT_IDLE = '0;
    localparam logic [W_MCNT-1:0] MCNT_LAST = W_MCNT'(1);
    localparam logic [W_MCNT-1:0] MCNT_LOAD = W_MCNT'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010, F_OR  = 3'b011,
        F_XOR = 3'b100, F_SLT = 3'b101, F_SLL = 3'b110, F_SRL = 3'b111
    } alu_func_e;

    // mcnt counts slice steps still owed after the issue cycle; the step taken
    // with mcnt == 1 is the last one and produces the broadcast.
    logic [W_MCNT-1:0]    mcnt;
    logic [W_PA_REG-1:0]  mul_dst;
    logic [W_PD_DATA-1:0] mul_mcand;
    logic [W_PD_DATA-1:0] mul_mplier;
    logic [W_PD_DATA-1:0] mul_prod;
    logic [W_PD_DATA-1:0] mul_step;

    logic [2:0]           sel_cls;
    alu_func_e            sel_func;
    logic                 issue;
    logic                 sel_alu;
    logic                 sel_mul;
    logic [W_PA_REG-1:0]  sel_dst;
    logic [W_PD_DATA-1:0] opb;
    logic [W_PD_DATA-1:0] alu_res;
    logic                 elig0;
    logic                 elig1;
    logic                 unused_pc;

    assign unused_pc = ^DFI_AA_pc;

    function automatic logic is_mul(input logic [W_PD_UOPS-1:0] u);
        return u[W_PD_UOPS-1 -: 3] == CLS_MUL;
    endfunction

    // A non-MUL op may not land on the writeback slot the finishing MUL owns.
    function automatic logic eligible(input logic [W_PD_UOPS-1:0] u,
                                      input logic [W_MCNT-1:0]    cnt);
        if (u == UNUSED_OP) return 1'b0;
        if (is_mul(u))      return cnt == MCNT_IDLE;
        return cnt != MCNT_LAST;
    endfunction

    assign elig0 = eligible(CDI_PD_uops0, mcnt);
    assign elig1 = eligible(CDI_PD_uops1, mcnt);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        CDO_PC_s1 = '0;
        if (CFI_PC_ena && !CFI_PC_stall && !CFI_PC_clear) begin
            if (elig0 && elig1)
                CDO_PC_s1 = CDI_PC_odr ? W_PC_SEL'(2'b10) : W_PC_SEL'(2'b01);
            else if (elig0)
                CDO_PC_s1 = W_PC_SEL'(2'b01);
            else if (elig1)
                CDO_PC_s1 = W_PC_SEL'(2'b10);
        end
    end

    assign issue    = |CDO_PC_s1;
    assign sel_cls  = DFI_PD_uops[W_PD_UOPS-1 -: 3];
    assign sel_func = alu_func_e'(DFI_PD_uops[2:0]);
    assign sel_alu  = issue && (sel_cls == CLS_ALU_RR || sel_cls == CLS_ALU_RI);
    assign sel_mul  = issue && (sel_cls == CLS_MUL);
    assign sel_dst  = CDO_PC_s1[1] ? CDI_PA_r2 : CDI_PA_r1;
    assign opb      = (sel_cls == CLS_ALU_RI) ? DFI_PD_imm : DFI_PD_rt;

    always_comb begin
        alu_res = '0;
        case (sel_func)
            F_ADD: alu_res = DFI_PD_rs + opb;
            F_SUB: alu_res = DFI_PD_rs - opb;
            F_AND: alu_res = DFI_PD_rs & opb;
            F_OR:  alu_res = DFI_PD_rs | opb;
            F_XOR: alu_res = DFI_PD_rs ^ opb;
            F_SLT: alu_res = W_PD_DATA'($signed(DFI_PD_rs) < $signed(opb));
            F_SLL: alu_res = DFI_PD_rs << opb[4:0];
            F_SRL: alu_res = DFI_PD_rs >> opb[4:0];
            default: alu_res = '0;
        endcase
    end

    // One radix-2^W_SLICE step: add the shifted multiplicand times the next slice.
    assign mul_step = mul_prod
                    + mul_mcand * {{(W_PD_DATA-W_SLICE){1'b0}}, mul_mplier[W_SLICE-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (CFI_PC_clear) begin
            mcnt         <= MCNT_IDLE;
            CDO_PV_upt1  <= 1'b0;
            CDO_PA_upt1  <= '0;
            CDO_PD_upt1  <= '0;
            CFO_PC_mbusy <= 1'b0;
        end else begin
            CFO_PC_mbusy <= sel_mul || (mcnt != MCNT_IDLE);
            if (mcnt == MCNT_LAST) begin
                CDO_PV_upt1 <= 1'b1;
                CDO_PA_upt1 <= mul_dst;
                CDO_PD_upt1 <= mul_step;
            end else if (sel_alu) begin
                CDO_PV_upt1 <= 1'b1;
                CDO_PA_upt1 <= sel_dst;
                CDO_PD_upt1 <= alu_res;
            end else begin
                CDO_PV_upt1 <= 1'b0;
            end
            if (sel_mul)
                mcnt <= MCNT_LOAD;
            else if (mcnt != MCNT_IDLE)
                mcnt <= mcnt - MCNT_LAST;
        end
    end

    // NOTE: MUL datapath registers carry no reset; mcnt alone decides whether they matter.
    always_ff @(posedge clk) begin
        if (sel_mul) begin
            mul_dst    <= sel_dst;
            mul_mcand  <= DFI_PD_rs << W_SLICE;
            mul_mplier <= DFI_PD_rt >> W_SLICE;
            mul_prod   <= DFI_PD_rs * {{(W_PD_DATA-W_SLICE){1'b0}}, DFI_PD_rt[W_SLICE-1:0]};
        end else if (mcnt != MCNT_IDLE) begin
            mul_mcand  <= mul_mcand << W_SLICE;
            mul_mplier <= mul_mplier >> W_SLICE;
            mul_prod   <= mul_step;
        end
    end

endmodule

// File: tb/tb_exec_pip0.sv
// Bench for exec_pip0: directed scenarios plus random traffic, checked against a
// cycle-numbered reference model of issue, MUL occupancy and broadcast.
module tb_exec_pip0;

    localparam logic [5:0] UNUSED = 6'b111111;
    localparam logic [5:0] OP_MUL = 6'b010000;
    localparam logic [5:0] OP_ADD = 6'b000000;

    logic        clk = 1'b0;
    logic        clear, ena, stall, odr;
    logic [5:0]  uops0, uops1, dfi_uops;
    logic [4:0]  r1, r2;
    logic [31:0] rs, rt, imm, pc;
    logic [1:0]  s1;
    logic        pv, mbusy;
    logic [4:0]  pa;
    logic [31:0] pd;

    always #5 clk = ~clk;

    exec_pip0 dut (
        .clk(clk), .CFI_PC_clear(clear), .CFI_PC_ena(ena), .CFI_PC_stall(stall),
        .CDI_PD_uops0(uops0), .CDI_PD_uops1(uops1), .CDI_PC_odr(odr),
        .CDI_PA_r1(r1), .CDI_PA_r2(r2), .DFI_PD_uops(dfi_uops),
        .DFI_PD_rs(rs), .DFI_PD_rt(rt), .DFI_PD_imm(imm), .DFI_AA_pc(pc),
        .CDO_PC_s1(s1), .CDO_PV_upt1(pv), .CDO_PA_upt1(pa), .CDO_PD_upt1(pd),
        .CFO_PC_mbusy(mbusy)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: cycle index, issue cycle of the live MUL, expected outputs.
    int          cyc = 0;
    int          last_mul = -100;
    logic [4:0]  m_mul_dst;
    logic [31:0] m_mul_res;
    logic        m_pv;
    logic [4:0]  m_pa;
    logic [31:0] m_pd;
    bit          m_known = 1'b0;
    logic [1:0]  exp_s1, last_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_is_mul(input logic [5:0] u);
        return u[5:3] == 3'b010;
    endfunction

    function automatic bit m_is_alu(input logic [5:0] u);
        return u[5:3] == 3'b000 || u[5:3] == 3'b001;
    endfunction

    // MUL issued at cycle i finishes at the end of cycle i+3; broadcast seen in i+4.
    function automatic bit m_inflight();
        return (cyc - last_mul) >= 1 && (cyc - last_mul) <= 3;
    endfunction

    function automatic bit m_elig(input logic [5:0] u);
        if (u == UNUSED) return 1'b0;
        if (m_is_mul(u)) return !m_inflight();
        return !(m_inflight() && cyc == last_mul + 3);
    endfunction

    function automatic logic [31:0] m_alu(input logic [5:0] u, input logic [31:0] a,
                                          input logic [31:0] t, input logic [31:0] i);
        logic [31:0] b;
        b = (u[5:3] == 3'b001) ? i : t;
        case (u[2:0])
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic logic [5:0] rand_uop();
        logic [5:0] u;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return UNUSED;
        if (r <= 2) return OP_MUL;
        u = 6'($urandom);
        if (u[5:3] == 3'b010) u[2:0] = 3'b000;
        return u;
    endfunction

    // One clock cycle: predict select, drive the selected uop, sample at negedge,
    // then advance the model across the rising edge.
    task automatic step();
        bit e0, e1;
        e0 = m_elig(uops0);
        e1 = m_elig(uops1);
        exp_s1 = 2'b00;
        if (ena && !stall && !clear) begin
            if (e0 && e1)  exp_s1 = odr ? 2'b10 : 2'b01;
            else if (e0)   exp_s1 = 2'b01;
            else if (e1)   exp_s1 = 2'b10;
        end
        dfi_uops = exp_s1[1] ? uops1 : (exp_s1[0] ? uops0 : 6'($urandom));
        pc = $urandom;
        @(negedge clk);
        last_s1 = s1;
        check("s1", 32'(s1), 32'(exp_s1));
        if (m_known) begin
            check("pv", 32'(pv), 32'(m_pv));
            check("pa", 32'(pa), 32'(m_pa));
            check("pd", pd, m_pd);
            check("mbusy", 32'(mbusy),
                  32'((cyc - last_mul) >= 1 && (cyc - last_mul) <= 4));
        end
        @(posedge clk);
        if (clear) begin
            m_pv = 1'b0; m_pa = '0; m_pd = '0;
            last_mul = -100;
            m_known = 1'b1;
        end else begin
            if (cyc == last_mul + 3) begin
                m_pv = 1'b1; m_pa = m_mul_dst; m_pd = m_mul_res;
            end else if (exp_s1 != 2'b00 && m_is_alu(dfi_uops)) begin
                m_pv = 1'b1;
                m_pa = exp_s1[1] ? r2 : r1;
                m_pd = m_alu(dfi_uops, rs, rt, imm);
            end else begin
                m_pv = 1'b0;
            end
            if (exp_s1 != 2'b00 && m_is_mul(dfi_uops)) begin
                last_mul  = cyc;
                m_mul_dst = exp_s1[1] ? r2 : r1;
                m_mul_res = 32'(64'(rs) * 64'(rt));
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_c(input logic [5:0] u0, input logic [4:0] a1,
                         input logic [5:0] u1, input logic [4:0] a2, input logic o);
        uops0 = u0; r1 = a1; uops1 = u1; r2 = a2; odr = o;
    endtask

    task automatic alu_case(input string tag, input logic [5:0] u, input logic [31:0] a,
                            input logic [31:0] t, input logic [31:0] i,
                            input logic [31:0] want);
        set_c(u, 5'd6, UNUSED, 5'd0, 1'b0);
        rs = a; rt = t; imm = i;
        step();
        check({tag, "_s1"}, 32'(last_s1), 32'd1);
        check({tag, "_pd"}, pd, want);
    endtask

    initial begin
        clear = 1'b1; ena = 1'b1; stall = 1'b0;
        set_c(UNUSED, 5'd0, UNUSED, 5'd0, 1'b0);
        rs = '0; rt = '0; imm = '0; pc = '0; dfi_uops = UNUSED;
        @(posedge clk); #1;
        step();
        step();
        check("rst_pv", 32'(pv), 32'd0);
        check("rst_pa", 32'(pa), 32'd0);
        check("rst_pd", pd, 32'd0);
        check("rst_mbusy", 32'(mbusy), 32'd0);
        clear = 1'b0;

        // Single add
        set_c(OP_ADD, 5'd3, UNUSED, 5'd0, 1'b0);
        rs = 32'd5; rt = 32'd7;
        step();
        check("add_s1", 32'(last_s1), 32'd1);
        check("add_pv", 32'(pv), 32'd1);
        check("add_pa", 32'(pa), 32'd3);
        check("add_pd", pd, 32'd12);

        // Age order
        set_c(OP_ADD, 5'd1, 6'b000001, 5'd2, 1'b1);
        rs = 32'd9; rt = 32'd4;
        step();
        check("age_old1", 32'(last_s1), 32'd2);
        check("age_old1_pd", pd, 32'd5);
        odr = 1'b0;
        step();
        check("age_old0", 32'(last_s1), 32'd1);
        check("age_old0_pd", pd, 32'd13);

        // MUL with an ALU op waiting on candidate 1
        set_c(OP_MUL, 5'd4, OP_ADD, 5'd9, 1'b0);
        rs = 32'h0001_0000; rt = 32'h0003_0003;
        step();
        check("mul_c0", 32'(last_s1), 32'd1);
        uops0 = UNUSED;
        rs = 32'd1; rt = 32'd2;
        step();
        check("mul_c1", 32'(last_s1), 32'd2);
        step();
        check("mul_c2", 32'(last_s1), 32'd2);
        step();
        check("mul_c3", 32'(last_s1), 32'd0);
        check("mul_pv", 32'(pv), 32'd1);
        check("mul_pa", 32'(pa), 32'd4);
        check("mul_pd", pd, 32'h0003_0000);
        step();
        check("mul_c4", 32'(last_s1), 32'd2);

        // Stall while a MUL is in flight
        set_c(OP_MUL, 5'd7, UNUSED, 5'd0, 1'b0);
        rs = 32'd1000; rt = 32'd3000;
        step();
        stall = 1'b1;
        set_c(OP_MUL, 5'd8, OP_ADD, 5'd10, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("stall_s1", 32'(last_s1), 32'd0);
            if (i == 3) begin
                check("stall_pv", 32'(pv), 32'd1);
                check("stall_pd", pd, 32'd3000000);
            end
        end
        stall = 1'b0;

        // Clear aborts a MUL
        set_c(OP_MUL, 5'd11, UNUSED, 5'd0, 1'b0);
        rs = 32'd6; rt = 32'd7;
        step();
        uops0 = UNUSED;
        step();
        clear = 1'b1;
        step();
        check("clr_mbusy", 32'(mbusy), 32'd0);
        clear = 1'b0;
        step();
        check("clr_no_bcast", 32'(pv), 32'd0);

        // Edge arithmetic
        alu_case("sub", 6'b000001, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF);
        alu_case("slt", 6'b000101, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        alu_case("sll", 6'b001110, 32'd1, 32'd0, 32'h21, 32'd2);
        set_c(6'b011000, 5'd12, UNUSED, 5'd0, 1'b0);
        step();
        check("nop_s1", 32'(last_s1), 32'd1);
        check("nop_pv", 32'(pv), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            uops0 = rand_uop();
            uops1 = rand_uop();
            r1 = 5'($urandom); r2 = 5'($urandom); odr = 1'($urandom);
            ena   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 49) == 0);
            rs = $urandom; rt = $urandom; imm = $urandom;
            step();
        end
        clear = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
